// File: rtl/elevator_call_panel_if.sv
// Hall-call offer channel: call panel (master) to car controller (slave).
interface elevator_call_panel_if #(
  parameter int FLOOR_W = 2
);
  logic               req_valid;
  logic [FLOOR_W-1:0] req_floor;
  logic               req_ready;

  modport master (
    output req_valid,
    output req_floor,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_floor,
    output req_ready
  );
endinterface

// File: rtl/elevator_call_panel.sv
// Hall call panel: debounce, latch, lamps, round-robin dispatch to the car.
// Optional macro CALL_TIMEOUT_EN re-offers dispatched calls left unserved.
module elevator_call_panel #(
  parameter int NUM_FLOORS      = 4,
  parameter int FLOOR_W         = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [FLOOR_W-1:0]    car_floor,
  input  logic                  car_at_floor,
  elevator_call_panel_if.master req,
  output logic [NUM_FLOORS-1:0] call_lamp,
  output logic                  pending
);

  if (NUM_FLOORS < 2 || NUM_FLOORS > 16 ||
      (1 << FLOOR_W) < NUM_FLOORS ||
      DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
    $error("elevator_call_panel: illegal parameters");
  end

  localparam logic [7:0] DB_MAX = 8'(DEBOUNCE_CYCLES);
  localparam logic [FLOOR_W-1:0] LAST = FLOOR_W'(NUM_FLOORS - 1);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t             st;
  logic               valid_q;
  logic [FLOOR_W-1:0] floor_q;
  logic [FLOOR_W-1:0] rr_ptr;
  logic [FLOOR_W-1:0] sel_idx;
  logic               sel_ok;

  logic [7:0]            db_cnt [NUM_FLOORS];
  logic [NUM_FLOORS-1:0] armed;
  logic [NUM_FLOORS-1:0] dispatched;
  logic [NUM_FLOORS-1:0] accept;
  logic [NUM_FLOORS-1:0] clr;
  logic [NUM_FLOORS-1:0] hs_vec;
  logic [NUM_FLOORS-1:0] to_hit;
  logic [NUM_FLOORS-1:0] elig;
  logic [NUM_FLOORS-1:0] lamp_nx;
  logic [NUM_FLOORS-1:0] disp_nx;
  logic                  car_ok;
  logic                  hs;
  logic                  off_clr;

  assign car_ok  = car_at_floor && (int'(car_floor) < NUM_FLOORS);
  assign hs      = valid_q && req.req_ready;
  assign off_clr = car_ok && (car_floor == floor_q);
  assign elig    = call_lamp & ~dispatched;

  always_comb begin
    accept = '0;
    clr    = '0;
    hs_vec = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      accept[i] = call_btn[i] && armed[i] &&
                  (db_cnt[i] == DB_MAX - 8'd1);
      clr[i]    = car_ok && (car_floor == FLOOR_W'(i));
      hs_vec[i] = hs && (floor_q == FLOOR_W'(i));
    end
  end

  // Arrival wins over a same-cycle press or acceptance.
  assign lamp_nx = (call_lamp | accept) & ~clr;
  assign disp_nx = (dispatched | hs_vec) & ~clr & ~to_hit;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_FLOORS; i++) db_cnt[i] <= '0;
      armed      <= '1;
      call_lamp  <= '0;
      dispatched <= '0;
      pending    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_FLOORS; i++) begin
        if (!call_btn[i]) begin
          db_cnt[i] <= '0;
          armed[i]  <= 1'b1;
        end else begin
          if (db_cnt[i] != DB_MAX) db_cnt[i] <= db_cnt[i] + 8'd1;
          if (accept[i]) armed[i] <= 1'b0;
        end
      end
      call_lamp  <= lamp_nx;
      dispatched <= disp_nx;
      pending    <= |lamp_nx;
    end
  end

`ifdef CALL_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] tmr [NUM_FLOORS];

  always_comb begin
    to_hit = '0;
    for (int i = 0; i < NUM_FLOORS; i++)
      to_hit[i] = dispatched[i] && call_lamp[i] && (tmr[i] == TO_LAST);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_FLOORS; i++) tmr[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_FLOORS; i++) begin
        if (!(dispatched[i] && call_lamp[i]) || clr[i] || to_hit[i])
          tmr[i] <= '0;
        else
          tmr[i] <= tmr[i] + 16'd1;
      end
    end
  end
`else
  assign to_hit = '0;
`endif

  // First eligible floor at or after the round-robin pointer.
  always_comb begin
    int j;
    j       = 0;
    sel_ok  = 1'b0;
    sel_idx = '0;
    for (int k = 0; k < NUM_FLOORS; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_FLOORS) j = j - NUM_FLOORS;
      if (!sel_ok && elig[j]) begin
        sel_ok  = 1'b1;
        sel_idx = FLOOR_W'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st      <= IDLE;
      valid_q <= 1'b0;
      floor_q <= '0;
      rr_ptr  <= '0;
    end else begin
      unique case (st)
        IDLE: begin
          if (sel_ok) begin
            valid_q <= 1'b1;
            floor_q <= sel_idx;
            st      <= OFFER;
          end
        end
        OFFER: begin
          if (req.req_ready) begin
            valid_q <= 1'b0;
            st      <= IDLE;
            rr_ptr  <= (floor_q == LAST) ? '0 : floor_q + 1'b1;
          end else if (off_clr) begin
            valid_q <= 1'b0;
            st      <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign req.req_valid = valid_q;
  assign req.req_floor = floor_q;

endmodule

// File: tb/tb_elevator_call_panel.sv
// Randomized scoreboard bench for elevator_call_panel (4 floors, debounce 4).
module tb_elevator_call_panel;
  localparam int N   = 4;
  localparam int FW  = 2;
  localparam int DEB = 4;
  localparam int TO  = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  call_btn;
  logic [FW-1:0] car_floor;
  logic          car_at_floor;
  logic [N-1:0]  call_lamp;
  logic          pending;

  elevator_call_panel_if #(.FLOOR_W(FW)) req_if ();

  elevator_call_panel #(
    .NUM_FLOORS(N),
    .FLOOR_W(FW),
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .call_btn(call_btn),
    .car_floor(car_floor),
    .car_at_floor(car_at_floor),
    .req(req_if),
    .call_lamp(call_lamp),
    .pending(pending)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int q[$];
  int ptr_m = 0;

`ifdef CALL_TIMEOUT_EN
  localparam bit RND_READY = 1'b0;
`else
  localparam bit RND_READY = 1'b1;
`endif

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: simultaneous calls are served in circular order from the
  // floor after the last one accepted.
  task automatic push_mask(input logic [N-1:0] mask);
    int f;
    int last;
    last = ptr_m;
    for (int k = 0; k < N; k++) begin
      f = (ptr_m + k) % N;
      if (mask[f]) begin
        q.push_back(f);
        last = f;
      end
    end
    ptr_m = (last + 1) % N;
  endtask

  logic          prev_v  = 1'b0;
  logic          prev_r  = 1'b0;
  logic          prev_hs = 1'b0;
  logic [FW-1:0] prev_f  = '0;

  always @(negedge clk) begin
    if (reset) begin
      if (prev_hs)
        check("idle_gap", int'(req_if.req_valid), 0);
      if (prev_v && !prev_r && req_if.req_valid)
        check("offer_stable", int'(req_if.req_floor), int'(prev_f));
      if (req_if.req_valid && req_if.req_ready) begin
        check("offer_expected", int'(q.size() != 0), 1);
        if (q.size() != 0)
          check("offer_floor", int'(req_if.req_floor), q.pop_front());
      end
    end
    prev_v  <= reset && req_if.req_valid;
    prev_r  <= req_if.req_ready;
    prev_f  <= req_if.req_floor;
    prev_hs <= reset && req_if.req_valid && req_if.req_ready;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int limit, input bit rnd);
    int n;
    n = 0;
    while (q.size() != 0 && n < limit) begin
      req_if.req_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step(1);
      n++;
    end
    check("drain_done", q.size(), 0);
    if (q.size() != 0) q.delete();
    req_if.req_ready = 1'b1;
  endtask

  task automatic arrive(input int f);
    car_floor    = FW'(f);
    car_at_floor = 1'b1;
    step(1);
    car_at_floor = 1'b0;
    check("clear_lamp", int'(call_lamp[f]), 0);
  endtask

  task automatic round(input logic [N-1:0] mask, input bit rnd);
    int s;
    call_btn = mask;
    step(DEB - 1);
    check("pre_latch", int'(call_lamp), 0);
    step(1);
    check("latch", int'(call_lamp), int'(mask));
    check("pending_on", int'(pending), 1);
    call_btn = '0;
    push_mask(mask);
    drain(300, rnd);
    check("lamps_held", int'(call_lamp), int'(mask));
    s = $urandom_range(0, N - 1);
    for (int k = 0; k < N; k++)
      if (mask[(s + k) % N]) arrive((s + k) % N);
    check("lamps_clear", int'(call_lamp), 0);
    check("pending_off", int'(pending), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset            = 1'b0;
    call_btn         = '1;
    car_floor        = '0;
    car_at_floor     = 1'b0;
    req_if.req_ready = 1'b0;
    step(3);
    check("rst_valid", int'(req_if.req_valid), 0);
    check("rst_floor", int'(req_if.req_floor), 0);
    check("rst_lamp", int'(call_lamp), 0);
    check("rst_pending", int'(pending), 0);

    reset = 1'b1;
    step(DEB - 1);
    check("rst_pre", int'(call_lamp), 0);
    step(1);
    check("rst_latch", int'(call_lamp), 15);
    push_mask(4'hF);
    drain(100, 1'b0);
    call_btn = '0;
    for (int f = 0; f < N; f++) arrive(f);
    check("rst_clear", int'(pending), 0);

    req_if.req_ready = 1'b0;
    call_btn = 4'b0100;
    step(3);
    call_btn = '0;
    step(1);
    call_btn = 4'b0100;
    step(3);
    check("db_pre", int'(call_lamp), 0);
    step(1);
    check("db_latch", int'(call_lamp), 4);
    check("db_valid_lag", int'(req_if.req_valid), 0);
    step(1);
    check("db_valid", int'(req_if.req_valid), 1);
    check("db_floor", int'(req_if.req_floor), 2);
    step(10);
    check("db_hold_valid", int'(req_if.req_valid), 1);
    check("db_hold_floor", int'(req_if.req_floor), 2);
    push_mask(4'b0100);
    drain(20, 1'b0);
    call_btn = '0;
    arrive(2);

    round(4'b1011, 1'b0);
    for (int r = 0; r < 12; r++)
      round(N'($urandom_range(1, 15)), RND_READY);

    call_btn = 4'b0010;
    step(DEB);
    check("held_latch", int'(call_lamp), 2);
    push_mask(4'b0010);
    drain(20, 1'b0);
    car_floor    = 2'd1;
    car_at_floor = 1'b1;
    step(1);
    check("held_clear", int'(call_lamp), 0);
    check("held_pending", int'(pending), 0);
    step(3);
    car_at_floor = 1'b0;
    step(10);
    check("held_no_relatch", int'(call_lamp), 0);
    call_btn = '0;
    step(1);
    call_btn = 4'b0010;
    step(DEB);
    check("repress_latch", int'(call_lamp), 2);
    push_mask(4'b0010);
    drain(20, 1'b0);
    call_btn = '0;
    arrive(1);

    req_if.req_ready = 1'b0;
    call_btn = 4'b1000;
    step(DEB);
    call_btn = '0;
    step(1);
    check("co_valid", int'(req_if.req_valid), 1);
    check("co_floor", int'(req_if.req_floor), 3);
    car_floor    = 2'd3;
    car_at_floor = 1'b1;
    step(1);
    car_at_floor = 1'b0;
    check("co_drop", int'(req_if.req_valid), 0);
    check("co_lamp", int'(call_lamp), 0);
    req_if.req_ready = 1'b1;
    step(20);
    check("co_no_reoffer", int'(req_if.req_valid), 0);

    car_floor    = 2'd0;
    car_at_floor = 1'b1;
    call_btn     = 4'b0001;
    step(DEB + 1);
    check("discard_lamp", int'(call_lamp), 0);
    call_btn     = '0;
    car_at_floor = 1'b0;
    step(2);
    check("discard_after", int'(call_lamp), 0);

    call_btn = 4'b0001;
    step(DEB);
    call_btn = '0;
    push_mask(4'b0001);
    drain(20, 1'b0);
`ifdef CALL_TIMEOUT_EN
    push_mask(4'b0001);
    drain(TO + 20, 1'b0);
`else
    step(1000);
    check("to_none_valid", int'(req_if.req_valid), 0);
    check("to_none_lamp", int'(call_lamp), 1);
`endif
    arrive(0);

    req_if.req_ready = 1'b0;
    call_btn = 4'b0100;
    step(DEB);
    call_btn = '0;
    step(1);
    check("mr_valid", int'(req_if.req_valid), 1);
    reset = 1'b0;
    step(1);
    check("mr_drop", int'(req_if.req_valid), 0);
    check("mr_lamp", int'(call_lamp), 0);
    check("mr_pending", int'(pending), 0);
    reset = 1'b1;
    step(2);
    check("mr_after", int'(req_if.req_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
